// File: rtl/storage_pkg.sv
// Shared types and constants for the storage write-port arbiter.
// Holds the arbiter state encoding, requester indices and the default beat width.
// No logic lives here; it is imported by storage_arbiter.
package storage_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Requester indices as seen on sto_src.
  localparam logic REQ_DATAPATH = 1'b0;  // acquisition data path
  localparam logic REQ_CMD      = 1'b1;  // rs232 command processor records

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/storage_arbiter.sv
// Round-robin arbiter sharing the storage_interface write port between two requesters.
// Latency: grant registered 1 cycle after req seen in IDLE; beats pass combinationally while granted.
// Backpressure: sto_ready passes straight to the granted wr_ready; optional idle timeout via STORAGE_ARB_TIMEOUT_EN.
module storage_arbiter
  import storage_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              wr_valid0,
  input  logic              wr_valid1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              wr_last0,
  input  logic              wr_last1,
  output logic              wr_ready0,
  output logic              wr_ready1,
  output logic              sto_valid,
  output logic [DATA_W-1:0] sto_data,
  output logic              sto_last,
  output logic              sto_src,
  input  logic              sto_ready,
  output logic              busy,
  output logic              timeout_flag
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic             last;        // requester served most recently
  logic [CNT_W-1:0] count;       // beats accepted in the current grant
  logic             in_grant;
  logic             sel_req;
  logic             sel_last;
  logic             accept;
  logic             at_cap;
  logic             burst_end;
  logic             timeout_hit;

  assign in_grant = (state == GRANT0) || (state == GRANT1);
  assign gnt0     = (state == GRANT0);
  assign gnt1     = (state == GRANT1);
  assign busy     = (state != IDLE);

  // Datapath mux: the granted requester is wired straight through to storage.
  always_comb begin
    sto_valid = 1'b0;
    sto_data  = '0;
    sto_src   = REQ_DATAPATH;
    wr_ready0 = 1'b0;
    wr_ready1 = 1'b0;
    sel_req   = 1'b0;
    sel_last  = 1'b0;
    case (state)
      GRANT0: begin
        sto_valid = wr_valid0;
        sto_data  = wr_data0;
        sto_src   = REQ_DATAPATH;
        wr_ready0 = sto_ready;
        sel_req   = req0;
        sel_last  = wr_last0;
      end
      GRANT1: begin
        sto_valid = wr_valid1;
        sto_data  = wr_data1;
        sto_src   = REQ_CMD;
        wr_ready1 = sto_ready;
        sel_req   = req1;
        sel_last  = wr_last1;
      end
      default: ;
    endcase
  end

  assign accept   = sto_valid && sto_ready;
  assign at_cap   = (count == CAP_CNT);
  assign sto_last = sto_valid && (sel_last || at_cap);
  // A requester that dropped req keeps the grant until its in-flight beat is gone.
  assign burst_end = in_grant &&
                     ((accept && (sel_last || at_cap)) ||
                      (!sel_req && !sto_valid) ||
                      timeout_hit);

  // Next-state: round-robin pick in IDLE, one-cycle RELEASE gap between grants.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = (last == REQ_CMD) ? GRANT0 : GRANT1;
        else if (req0)     state_nxt = GRANT0;
        else if (req1)     state_nxt = GRANT1;
      end
      GRANT0, GRANT1: if (burst_end) state_nxt = RELEASE;
      RELEASE:        state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Round-robin pointer, captured as the grant ends so IDLE sees it after RELEASE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         last <= REQ_CMD;
    else if (burst_end) last <= sto_src;
  end

  // Beat counter; cleared in RELEASE, cannot wrap since MAX_BURST forces release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (state == RELEASE)  count <= '0;
    else if (accept)            count <= count + CNT_W'(1);
  end

`ifdef STORAGE_ARB_TIMEOUT_EN
  localparam int                IDLE_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_TC = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive granted cycle without a valid beat.
  assign timeout_hit = in_grant && !sto_valid && (idle_cnt == IDLE_TC);

  // Idle counter: a presented beat (even a stalled one) restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     idle_cnt <= '0;
    else if (!in_grant || sto_valid) idle_cnt <= '0;
    else                            idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // Flag pulses during the RELEASE cycle of a forced release only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timeout_flag <= 1'b0;
    else        timeout_flag <= timeout_hit && sel_req;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: grant timing, round-robin, burst cap,
// backpressure, reset abort and idle timeout (STORAGE_ARB_TIMEOUT_EN aware).
// Transfers are logged before each edge and compared to hand-computed values.
module tb_storage_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       gnt0, gnt1;
  logic       wr_valid0 = 1'b0, wr_valid1 = 1'b0;
  logic [7:0] wr_data0 = '0, wr_data1 = '0;
  logic       wr_last0 = 1'b0, wr_last1 = 1'b0;
  logic       wr_ready0, wr_ready1;
  logic       sto_valid;
  logic [7:0] sto_data;
  logic       sto_last;
  logic       sto_src;
  logic       sto_ready = 1'b1;
  logic       busy;
  logic       timeout_flag;

  int n_chk = 0;
  int n_pass = 0;

  // Requester source models.
  int         left0 = 0, left1 = 0, cnt0 = 0, cnt1 = 0;
  bit         lastf0 = 0, lastf1 = 0;
  logic [7:0] base0 = '0, base1 = '0;
  bit         toggle_en = 0;

  logic [9:0] log_q[$];  // {src, last, data} per transfer

  always #5 clock = ~clock;

  storage_arbiter #(.DATA_W(8), .MAX_BURST(16), .TIMEOUT_CYC(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .wr_valid0(wr_valid0), .wr_valid1(wr_valid1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_last0(wr_last0), .wr_last1(wr_last1),
    .wr_ready0(wr_ready0), .wr_ready1(wr_ready1),
    .sto_valid(sto_valid), .sto_data(sto_data), .sto_last(sto_last),
    .sto_src(sto_src), .sto_ready(sto_ready),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load(input int idx, input int n, input bit with_last, input logic [7:0] base);
    if (idx == 0) begin
      left0 = n; cnt0 = 0; base0 = base; lastf0 = with_last;
      req0 = 1'b1; wr_valid0 = 1'b1; wr_data0 = base; wr_last0 = (n == 1) && with_last;
    end else begin
      left1 = n; cnt1 = 0; base1 = base; lastf1 = with_last;
      req1 = 1'b1; wr_valid1 = 1'b1; wr_data1 = base; wr_last1 = (n == 1) && with_last;
    end
  endtask

  // One clock: log the transfer about to happen, advance sources that were accepted.
  task automatic cycle();
    bit a0, a1;
    a0 = wr_valid0 && wr_ready0;
    a1 = wr_valid1 && wr_ready1;
    if (reset && sto_valid && sto_ready) log_q.push_back({sto_src, sto_last, sto_data});
    @(posedge clock); #1;
    if (a0) begin
      cnt0++; left0--;
      if (left0 == 0) begin wr_valid0 = 1'b0; req0 = 1'b0; wr_last0 = 1'b0; end
      else begin wr_data0 = base0 + 8'(cnt0); wr_last0 = (left0 == 1) && lastf0; end
    end
    if (a1) begin
      cnt1++; left1--;
      if (left1 == 0) begin wr_valid1 = 1'b0; req1 = 1'b0; wr_last1 = 1'b0; end
      else begin wr_data1 = base1 + 8'(cnt1); wr_last1 = (left1 == 1) && lastf1; end
    end
    if (toggle_en) sto_ready = ~sto_ready;
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (!(left0 == 0 && left1 == 0 && !busy) && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, 32'(left0 == 0 && left1 == 0 && !busy), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    left0 = 0; left1 = 0;
    req0 = 1'b0; req1 = 1'b0; wr_valid0 = 1'b0; wr_valid1 = 1'b0;
    wr_last0 = 1'b0; wr_last1 = 1'b0; wr_data0 = '0; wr_data1 = '0;
    sto_ready = 1'b1; toggle_en = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tflag", 32'(timeout_flag), 0);
    chk("rst_sto_valid", 32'(sto_valid), 0);
    chk("rst_ready", 32'({wr_ready0, wr_ready1, sto_last}), 0);
    do_reset();

    // Single requester, 3 beats with last on beat 3
    load(0, 3, 1, 8'h10); #1;
    chk("t1_no_gnt_yet", 32'(gnt0), 0);
    cycle();
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_src", 32'(sto_src), 0);
    chk("t1_rdy0", 32'({wr_ready0, wr_ready1}), 32'b10);
    chk("t1_data0", 32'(sto_data), 32'h10);
    cycle();
    chk("t1_data1", 32'(sto_data), 32'h11);
    chk("t1_nolast", 32'(sto_last), 0);
    cycle();
    chk("t1_last", 32'(sto_last), 1);
    cycle();
    chk("t1_release_gnt", 32'(gnt0), 0);
    chk("t1_release_busy", 32'(busy), 1);
    cycle();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_nbeats", 32'(log_q.size()), 3);
    if (log_q.size() == 3) chk("t1_beat3", 32'(log_q[2]), 32'({1'b0, 1'b1, 8'h12}));

    // Contention out of reset: requester 0 first, requester 1 two cycles after release
    do_reset(); log_q.delete();
    load(0, 2, 1, 8'h20); load(1, 2, 1, 8'h30); #1;
    cycle();
    chk("t2_gnt", 32'({gnt0, gnt1}), 32'b10);
    cycle(); cycle();
    chk("t2_release", 32'({gnt0, gnt1}), 32'b00);
    cycle();
    chk("t2_idle", 32'({gnt0, gnt1}), 32'b00);
    cycle();
    chk("t2_gnt1", 32'({gnt0, gnt1}), 32'b01);
    chk("t2_src1", 32'(sto_src), 1);
    drain("t2_drain", 50);
    chk("t2_nbeats", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      chk("t2_b1", 32'(log_q[1]), 32'({1'b0, 1'b1, 8'h21}));
      chk("t2_b2", 32'(log_q[2]), 32'({1'b1, 1'b0, 8'h30}));
      chk("t2_b3", 32'(log_q[3]), 32'({1'b1, 1'b1, 8'h31}));
    end

    // Burst cap: requester 1 streams 40 beats, requester 0 pending mid-burst
    log_q.delete();
    load(1, 40, 0, 8'h40); #1;
    cycle();
    chk("t3_gnt1", 32'(gnt1), 1);
    repeat (3) cycle();
    load(0, 2, 1, 8'h00); #1;
    drain("t3_drain", 300);
    chk("t3_nbeats", 32'(log_q.size()), 42);
    if (log_q.size() == 42) begin
      chk("t3_b14", 32'(log_q[14]), 32'({1'b1, 1'b0, 8'h4E}));
      chk("t3_cap16", 32'(log_q[15]), 32'({1'b1, 1'b1, 8'h4F}));
      chk("t3_rr0a", 32'(log_q[16]), 32'({1'b0, 1'b0, 8'h00}));
      chk("t3_rr0b", 32'(log_q[17]), 32'({1'b0, 1'b1, 8'h01}));
      chk("t3_resume", 32'(log_q[18]), 32'({1'b1, 1'b0, 8'h50}));
      chk("t3_cap32", 32'(log_q[33]), 32'({1'b1, 1'b1, 8'h5F}));
      chk("t3_tail", 32'(log_q[41]), 32'({1'b1, 1'b0, 8'h67}));
    end

    // Backpressure: sto_ready toggles every cycle across an 8-beat burst
    log_q.delete();
    toggle_en = 1;
    load(1, 8, 1, 8'hA0); #1;
    drain("t4_drain", 100);
    toggle_en = 0; sto_ready = 1'b1; #1;
    chk("t4_nbeats", 32'(log_q.size()), 8);
    if (log_q.size() == 8)
      for (int i = 0; i < 8; i++)
        chk($sformatf("t4_b%0d", i), 32'(log_q[i]), 32'({1'b1, (i == 7) ? 1'b1 : 1'b0, 8'hA0 + 8'(i)}));

    // Reset mid-burst: pointer returns to requester 1 so requester 0 wins next contention
    load(0, 1, 1, 8'hB0); #1;
    drain("t5_pre", 20);
    log_q.delete();
    load(0, 10, 1, 8'hC0); #1;
    cycle();
    repeat (4) cycle();
    chk("t5_beat5", 32'(sto_data), 32'hC4);
    reset = 1'b0; #1;
    chk("t5_rst_gnt", 32'({gnt0, gnt1}), 0);
    chk("t5_rst_valid", 32'({sto_valid, wr_ready0}), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_nbeats_abort", 32'(log_q.size()), 4);
    cycle();
    reset = 1'b1;
    load(1, 2, 1, 8'hD0); #1;
    cycle();
    chk("t5_ptr_reset", 32'({gnt0, gnt1}), 32'b10);
    drain("t5_drain", 100);
    chk("t5_nbeats", 32'(log_q.size()), 12);
    if (log_q.size() == 12) begin
      chk("t5_resume", 32'(log_q[4]), 32'({1'b0, 1'b0, 8'hC4}));
      chk("t5_end0", 32'(log_q[9]), 32'({1'b0, 1'b1, 8'hC9}));
      chk("t5_then1", 32'(log_q[10]), 32'({1'b1, 1'b0, 8'hD0}));
    end

    // Silent requester holding req0
    req0 = 1'b1; #1;
    cycle();
    chk("t6_gnt", 32'(gnt0), 1);
`ifdef STORAGE_ARB_TIMEOUT_EN
    repeat (7) cycle();
    chk("t6_hold8", 32'({gnt0, timeout_flag}), 32'b10);
    cycle();
    chk("t6_forced", 32'({gnt0, timeout_flag}), 32'b01);
    cycle();
    chk("t6_pulse1", 32'(timeout_flag), 0);
    req0 = 1'b0; #1;
`else
    repeat (20) cycle();
    chk("t6_held", 32'({gnt0, timeout_flag}), 32'b10);
    req0 = 1'b0; #1;
    cycle();
    chk("t6_drop", 32'({gnt0, timeout_flag}), 32'b00);
`endif
    drain("t6_drain", 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/storage_arbiter.md
# storage_arbiter

Shares the single storage_interface write port between two requesters: the acquisition data path (output of data_buffer_inst_2, requester 0) and rs232_command_processor (requester 1, e.g. logging and configuration records). It grants the port to one requester at a time using round-robin, and forwards beats over a valid/ready handshake. Each grant is bounded by a maximum burst length and, optionally, an idle timeout, so neither requester can starve the other. It sits between the two requesters and storage_interface, clocked from osc_clk.

## Interface
Parameters:
- DATA_W, 8, width of a data beat
- MAX_BURST, 16, maximum beats per grant (2..255)
- TIMEOUT_CYC, 1024, idle cycles before forced release (only used with STORAGE_ARB_TIMEOUT_EN)

Ports:
- clock  in  1  system clock (osc_clk)
- reset  in  1  asynchronous, active-low reset
- req0, req1  in  1  request for the storage port
- gnt0, gnt1  out  1  registered grant; one-hot or zero
- wr_valid0, wr_valid1  in  1  beat valid from requester
- wr_data0, wr_data1  in  DATA_W  beat data
- wr_last0, wr_last1  in  1  final beat of requester's record
- wr_ready0, wr_ready1  out  1  beat accepted when valid&ready
- sto_valid  out  1  beat valid to storage_interface
- sto_data  out  DATA_W  muxed beat data
- sto_last  out  1  last beat of this grant
- sto_src  out  1  index of the granted requester
- sto_ready  in  1  storage_interface accepts beat
- busy  out  1  high in any state except IDLE
- timeout_flag  out  1  one-cycle pulse on timeout release (tied 0 without macro)

## Operation
- FSM states: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE: if either req is high, go to GRANTn. When both are high, the winner is the requester not served last (round-robin pointer `last`). The pointer resets to 1, so requester 0 wins the first contention.
- GRANTn: gntn=1. The datapath is combinational pass-through: sto_valid=wr_validn, sto_data=wr_datan, sto_src=n, wr_readyn=sto_ready. The non-granted wr_ready is 0.
- The beat counter increments on each accepted beat (sto_valid&sto_ready).
- Burst ends (go to RELEASE) on any of:
  - an accepted beat with wr_lastn=1;
  - an accepted beat that is number MAX_BURST;
  - reqn=0 and wr_validn=0 (voluntary drop).
- sto_last = sto_valid & (wr_lastn | count==MAX_BURST-1).
- If reqn falls while wr_validn=1, the beat still completes; release waits for the condition above.
- RELEASE: both grants 0 for exactly one cycle. Set last=n, clear the counter, go to IDLE.
- A request arriving from the other side during GRANTn is held pending. It is served after RELEASE and IDLE.
- Beat counter width is clog2(MAX_BURST+1). It cannot wrap because release is forced at MAX_BURST.

## Timing
- Reset values (asserted asynchronously):
  - gnt0=gnt1=0, busy=0, timeout_flag=0, last=1, counter=0, state=IDLE;
  - sto_valid, wr_ready0, wr_ready1 and sto_last are 0 because no grant is active.
- Reset mid-burst aborts immediately; no beat completes in the reset cycle.
- Latency: req sampled high in IDLE -> gnt high on the next edge. The first beat can be accepted in that same cycle.
- Grant-to-grant turnaround is 2 cycles minimum (RELEASE + IDLE).
- A beat transfers on any edge where valid&ready are both high. Requesters must hold data/last stable while valid=1 and ready=0.

## Configuration
- STORAGE_ARB_TIMEOUT_EN defined:
  - an idle counter runs in GRANTn and counts consecutive cycles with wr_validn=0; it clears on wr_validn=1 or leaving the state;
  - reaching TIMEOUT_CYC forces RELEASE and pulses timeout_flag for 1 cycle.
  - Stalls where sto_ready=0 do not count.
- Undefined: no idle counter, timeout_flag is tied 0, and a silent requester holding req keeps the grant indefinitely.

## Structure
- Shared package storage_pkg holds:
  - the state enum (IDLE/GRANT0/GRANT1/RELEASE);
  - requester index constants REQ_DATAPATH=0, REQ_CMD=1;
  - the default DATA_W.
- No sub-module is required. The optional idle timer may be split out as arb_idle_timer (counter + terminal-count pulse).

## Test plan
- Single requester: req0=1, then 3 beats with last on beat 3 and sto_ready=1 -> gnt0 rises 1 cycle after req0, sto_src=0, 3 beats pass, sto_last on beat 3, RELEASE, busy=0 two cycles after the last beat.
- Contention out of reset: req0=req1=1 simultaneously -> gnt0 first. After its 2-beat burst, gnt1 is asserted 2 cycles later (round-robin).
- Burst cap with MAX_BURST=16: requester 1 streams 40 beats with no last -> forced sto_last on beat 16, release, requester 0 is served if pending, then requester 1 resumes.
- Backpressure: sto_ready toggles 0/1 every cycle during an 8-beat burst -> exactly 8 transfers, data order preserved, no duplicated or dropped beats.
- Reset mid-burst: reset low at beat 5 of 10 -> all grants and valid outputs 0 immediately; after release, req1 is served first only if req0 is low (pointer=1).
- STORAGE_ARB_TIMEOUT_EN with TIMEOUT_CYC=8: grant to requester 0, which holds req0 with no valid -> release after 8 idle cycles and timeout_flag pulses for 1 cycle. Without the macro, the grant is held and the flag stays 0.
